// File: rtl/writeback_controller.sv
// Register-file write-back sequencer: issues ALU/link writes directly and runs
// the data-memory read handshake (with timeout) for loads before writing.
module writeback_controller #(
    parameter int RADDR_W     = 5,
    parameter int AW          = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [1:0]         wb_kind,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [AW-1:0]      wb_addr,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    output logic [1:0]         mem_reg_pc,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic               busy,
    output logic               err_timeout
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_REQ  = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_WRITE    = 2'd3;

    localparam logic [1:0] K_REG  = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_LINK = 2'b10;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          expired;
    logic          rd_nonzero;

    assign wb_ready   = (state == S_IDLE) || (state == S_WRITE);
    assign busy       = (state == S_MEM_REQ) || (state == S_MEM_WAIT);
    assign accept     = wb_valid && wb_ready;
    // A grant at the expiry cycle moves to MEM_WAIT with cnt past the limit,
    // so >= makes that load abort one cycle later unless rvalid shows up.
    assign expired    = (cnt >= CW'(MEM_TIMEOUT - 1));
    assign rd_nonzero = (rf_waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_reg_pc  <= 2'b00;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            rf_we       <= 1'b0;
            case (state)
                S_IDLE, S_WRITE: begin
                    mem_reg_pc <= 2'b00;
                    state      <= S_IDLE;
                    if (accept) begin
                        case (wb_kind)
                            K_REG, K_LINK: begin
                                state      <= S_WRITE;
                                rf_we      <= (wb_rd != '0);
                                mem_reg_pc <= wb_kind;
                                rf_waddr   <= wb_rd;
                            end
                            K_LOAD: begin
                                state      <= S_MEM_REQ;
                                mem_req    <= 1'b1;
                                mem_addr   <= wb_addr;
                                mem_reg_pc <= K_LOAD;
                                rf_waddr   <= wb_rd;
                                cnt        <= '0;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_MEM_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            state <= S_WRITE;
                            rf_we <= rd_nonzero;
                        end else begin
                            state <= S_MEM_WAIT;
                        end
                    end else if (expired) begin
                        state       <= S_IDLE;
                        mem_req     <= 1'b0;
                        mem_reg_pc  <= 2'b00;
                        err_timeout <= 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (mem_rvalid) begin
                        state <= S_WRITE;
                        rf_we <= rd_nonzero;
                    end else if (expired) begin
                        state       <= S_IDLE;
                        mem_reg_pc  <= 2'b00;
                        err_timeout <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_controller.sv
// Scoreboard bench for writeback_controller: directed requests push expected
// register writes; a negedge monitor pops and compares every rf_we pulse.
module tb_writeback_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_kind;
    logic [4:0]  wb_rd;
    logic [31:0] wb_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [1:0]  mem_reg_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        busy;
    logic        err_timeout;

    typedef struct {
        logic [4:0] rd;
        logic [1:0] sel;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    writeback_controller #(.RADDR_W(5), .AW(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_kind(wb_kind),
        .wb_rd(wb_rd), .wb_addr(wb_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_reg_pc(mem_reg_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] addr);
        wb_valid = 1'b1;
        wb_kind  = kind;
        wb_rd    = rd;
        wb_addr  = addr;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [1:0] sel);
        wr_t w;
        w.rd  = rd;
        w.sel = sel;
        exp_q.push_back(w);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got waddr=%0d sel=%0b expected no write", rf_waddr, mem_reg_pc);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", 64'(rf_waddr), 64'(w.rd));
                chk("write_sel", 64'(mem_reg_pc), 64'(w.sel));
            end
        end
    end

    initial begin
        int nreq, addr_bad, ready_bad, err_first, err_cnt;
        logic ready_at_err, req_before_err;

        rst = 1'b0; wb_valid = 1'b0; wb_kind = 2'b00; wb_rd = '0; wb_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        repeat (3) cyc();
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_sel", 64'(mem_reg_pc), 0);
        chk("rst_rf_we", 64'(rf_we), 0);
        chk("rst_waddr", 64'(rf_waddr), 0);
        chk("rst_err", 64'(err_timeout), 0);
        chk("rst_ready", 64'(wb_ready), 1);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b1;
        cyc();

        // ALU write, single-cycle pulse
        issue(2'b00, 5'd3, 32'h0); expect_wr(5'd3, 2'b00);
        cyc(); wb_valid = 1'b0;
        chk("t1_we", 64'(rf_we), 1);
        cyc();
        chk("t1_we_end", 64'(rf_we), 0);

        // Back-to-back link then ALU
        issue(2'b10, 5'd31, 32'h0); expect_wr(5'd31, 2'b10);
        cyc();
        chk("t2_ready", 64'(wb_ready), 1);
        issue(2'b00, 5'd4, 32'h0); expect_wr(5'd4, 2'b00);
        cyc(); wb_valid = 1'b0;
        chk("t2_second_we", 64'(rf_we), 1);
        chk("t2_ready2", 64'(wb_ready), 1);
        cyc();
        chk("t2_we_end", 64'(rf_we), 0);
        chk("t2_sel_idle", 64'(mem_reg_pc), 0);

        // Kind 11: no write-back
        issue(2'b11, 5'd9, 32'h0);
        cyc(); wb_valid = 1'b0;
        chk("k11_we", 64'(rf_we), 0);
        chk("k11_ready", 64'(wb_ready), 1);
        cyc();

        // Load: gnt on 3rd cycle, rvalid 3 later; spurious rvalid before gnt; inputs changed after accept
        issue(2'b01, 5'd7, 32'h40); expect_wr(5'd7, 2'b01);
        cyc(); wb_valid = 1'b0; wb_addr = 32'hdead; wb_rd = 5'd2;
        nreq = 0; addr_bad = 0; ready_bad = 0;
        for (int i = 1; i <= 7; i++) begin
            mem_gnt    = (i == 3);
            mem_rvalid = (i == 2) || (i == 6);
            if (mem_req) begin
                nreq++;
                if (mem_addr != 32'h40) addr_bad++;
            end
            if (i <= 6 && wb_ready) ready_bad++;
            cyc();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("t3_req_cycles", 64'(nreq), 3);
        chk("t3_addr_bad", 64'(addr_bad), 0);
        chk("t3_ready_low", 64'(ready_bad), 0);
        cyc();

        // Grant and rvalid together -> WRITE next cycle
        issue(2'b01, 5'd9, 32'h80); expect_wr(5'd9, 2'b01);
        cyc(); wb_valid = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("t4_we", 64'(rf_we), 1);
        chk("t4_req_drop", 64'(mem_req), 0);
        cyc();

        // Timeout: never granted
        issue(2'b01, 5'd5, 32'h100);
        cyc(); wb_valid = 1'b0;
        err_first = 0; err_cnt = 0; ready_at_err = 1'b0; req_before_err = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 14) req_before_err = mem_req;
            if (err_timeout) begin
                err_cnt++;
                if (err_first == 0) begin
                    err_first    = k;
                    ready_at_err = wb_ready;
                end
            end
        end
        chk("t5_err_cycle", 64'(err_first), 15);
        chk("t5_err_pulses", 64'(err_cnt), 1);
        chk("t5_ready_after", 64'(ready_at_err), 1);
        chk("t5_req_held", 64'(req_before_err), 1);
        chk("t5_req_off", 64'(mem_req), 0);

        // rvalid exactly at expiry wins
        issue(2'b01, 5'd12, 32'h200); expect_wr(5'd12, 2'b01);
        cyc(); wb_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0;
        repeat (13) cyc();
        mem_rvalid = 1'b1;
        cyc(); mem_rvalid = 1'b0;
        chk("exp_win_err", 64'(err_timeout), 0);
        chk("exp_win_we", 64'(rf_we), 1);
        cyc();

        // rd=0 load sequenced but never writes
        issue(2'b01, 5'd0, 32'h4);
        cyc(); wb_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
        cyc(); mem_rvalid = 1'b0;
        chk("t6_rd0_we", 64'(rf_we), 0);
        chk("t6_rd0_ready", 64'(wb_ready), 1);
        cyc();

        // Reset in MEM_WAIT drops the load
        issue(2'b01, 5'd6, 32'h8);
        cyc(); wb_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0;
        chk("t6_in_wait", 64'(busy), 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_req", 64'(mem_req), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_sel", 64'(mem_reg_pc), 0);
        chk("t6_rst_waddr", 64'(rf_waddr), 0);
        chk("t6_rst_addr", 64'(mem_addr), 0);
        cyc(); rst = 1'b1; mem_rvalid = 1'b1;
        cyc(); mem_rvalid = 1'b0;
        chk("t6_late_rvalid", 64'(rf_we), 0);
        repeat (2) cyc();

        chk("scoreboard_drain", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
